// File: rtl/irq_ctrl_axi_if.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl_axi_if
//  Brief    : AXI4-Lite register-bus bundle for the interrupt controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface irq_ctrl_axi_if;
    logic [11:0] awaddr;
    logic [3:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic [3:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl_axi.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl_axi
//  Brief    : AXI4-Lite interrupt controller: per-source enable, edge/level
//             mode, pending with W1C, priority claim, registered irq.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl_axi #(
    parameter int NUM_SRC = 8
) (
    input  wire logic               aclk,
    input  wire logic               aresetn,
    irq_ctrl_axi_if.slave           bus,
    input  wire logic [NUM_SRC-1:0] src,
    output logic                    irq
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_RRESP = 3'd4;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [9:0]         r_addr;
    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC-1:0] r_pend_edge;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_edge;
    logic               r_irq;
    logic [31:0]        r_rdata;
    logic [1:0]         r_bresp;
    logic [1:0]         r_rresp;

    logic               w_addr_ok;
    logic               w_wr_fire;
    logic               w_rd_fire;
    logic [NUM_SRC-1:0] w_wmask;
    logic [NUM_SRC-1:0] w_wdata_m;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_pending;
    logic [NUM_SRC-1:0] w_active;
    logic [NUM_SRC-1:0] w_claim_hot;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pend_edge_nxt;
    logic [31:0]        w_claim_id;
    logic [31:0]        w_pend32;
    logic [31:0]        w_en32;
    logic [31:0]        w_edge32;
    logic [31:0]        w_rd_data;
    logic               w_unused;

    // Protection bits and byte-offset address bits carry no meaning here.
    assign w_unused = ^{bus.awprot, bus.arprot, bus.awaddr[1:0], bus.araddr[1:0], bus.wdata};

    assign w_addr_ok = (r_addr < 10'd4);
    assign w_wr_fire = (r_state == S_WRITE) && bus.wvalid && w_addr_ok;
    assign w_rd_fire = (r_state == S_READ) && w_addr_ok;

    // Byte strobes expanded to a per-source bit mask.
    always_comb begin
        w_wmask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_wmask[i] = bus.wstrb[i/8];
        end
    end

    assign w_wdata_m = bus.wdata[NUM_SRC-1:0] & w_wmask;
    assign w_rise    = src & ~r_src_q;

    // Level sources mirror the delayed input; edge sources use the sticky bit.
    assign w_pending = (r_edge & r_pend_edge) | (~r_edge & r_src_q);
    assign w_active  = w_pending & r_enable;

    // Lowest-numbered active source wins the claim.
    always_comb begin
        w_claim_id  = '0;
        w_claim_hot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_claim_id     = 32'(i + 1);
                w_claim_hot    = '0;
                w_claim_hot[i] = 1'b1;
            end
        end
    end

    // Clears from W1C and claim; a simultaneous rise overrides them.
    always_comb begin
        w_clr = '0;
        if (w_wr_fire && (r_addr == 10'd0)) begin
            w_clr = w_clr | w_wdata_m;
        end
        if (w_rd_fire && (r_addr == 10'd3)) begin
            w_clr = w_clr | w_claim_hot;
        end
        w_pend_edge_nxt = ((r_pend_edge & ~w_clr) | w_rise) & r_edge;
    end

    // Zero-extended register views and the read mux.
    always_comb begin
        w_pend32 = '0;
        w_en32   = '0;
        w_edge32 = '0;
        w_pend32[NUM_SRC-1:0] = w_pending;
        w_en32[NUM_SRC-1:0]   = r_enable;
        w_edge32[NUM_SRC-1:0] = r_edge;
        case (r_addr)
            10'd0:   w_rd_data = w_pend32;
            10'd1:   w_rd_data = w_en32;
            10'd2:   w_rd_data = w_edge32;
            10'd3:   w_rd_data = w_claim_id;
            default: w_rd_data = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; write wins when both channels request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.awvalid) begin
                    w_state_nxt = S_WRITE;
                end else if (bus.arvalid) begin
                    w_state_nxt = S_READ;
                end
            end
            S_WRITE: if (bus.wvalid) w_state_nxt = S_WRESP;
            S_WRESP: if (bus.bready) w_state_nxt = S_IDLE;
            S_READ:  w_state_nxt = S_RRESP;
            S_RRESP: if (bus.rready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; response valids drop as soon as reset is asserted.
    always_comb begin
        bus.awready = (r_state == S_IDLE);
        bus.arready = (r_state == S_IDLE);
        bus.wready  = (r_state == S_WRITE);
        bus.bvalid  = (r_state == S_WRESP) && aresetn;
        bus.rvalid  = (r_state == S_RRESP) && aresetn;
    end

    // Register file, edge detect, irq and response capture.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_addr      <= '0;
            r_src_q     <= '0;
            r_pend_edge <= '0;
            r_enable    <= '0;
            r_edge      <= '0;
            r_irq       <= 1'b0;
            r_rdata     <= '0;
            r_bresp     <= c_resp_okay;
            r_rresp     <= c_resp_okay;
        end else begin
            r_src_q     <= src;
            r_pend_edge <= w_pend_edge_nxt;
            r_irq       <= |w_active;
            if (r_state == S_IDLE) begin
                if (bus.awvalid) begin
                    r_addr <= bus.awaddr[11:2];
                end else if (bus.arvalid) begin
                    r_addr <= bus.araddr[11:2];
                end
            end
            if (w_wr_fire && (r_addr == 10'd1)) begin
                r_enable <= (r_enable & ~w_wmask) | w_wdata_m;
            end
            if (w_wr_fire && (r_addr == 10'd2)) begin
                r_edge <= (r_edge & ~w_wmask) | w_wdata_m;
            end
            if ((r_state == S_WRITE) && bus.wvalid) begin
                r_bresp <= w_addr_ok ? c_resp_okay : c_resp_decerr;
            end
            if (r_state == S_READ) begin
                r_rresp <= w_addr_ok ? c_resp_okay : c_resp_decerr;
                r_rdata <= w_rd_data;
            end
        end
    end

    assign irq       = r_irq;
    assign bus.rdata = r_rdata;
    assign bus.bresp = r_bresp;
    assign bus.rresp = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl_axi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_ctrl_axi
//  Brief    : Directed self-checking bench for irq_ctrl_axi.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl_axi;

    localparam int NUM_SRC = 16;
    localparam int LIMIT   = 20;

    logic               aclk;
    logic               aresetn;
    logic [NUM_SRC-1:0] src;
    logic               irq;

    int n_checks;
    int n_errors;

    irq_ctrl_axi_if bus ();

    irq_ctrl_axi #(.NUM_SRC(NUM_SRC)) u_dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus),
        .src     (src),
        .irq     (irq)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int bdelay,
                             input logic [NUM_SRC-1:0] src_at_w,
                             output logic [1:0] resp);
        int n;
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bus.awready && n < LIMIT);
        check("aw_ready", 32'(bus.awready), 32'd1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        src         = src | src_at_w;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bus.wready && n < LIMIT);
        check("w_ready", 32'(bus.wready), 32'd1);
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bus.bvalid && n < LIMIT);
        for (int k = 0; k < bdelay; k++) begin
            check("bvalid_hold", 32'(bus.bvalid), 32'd1);
            @(negedge aclk);
        end
        check("bvalid", 32'(bus.bvalid), 32'd1);
        resp       = bus.bresp;
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] addr, input int rdelay,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bus.arready && n < LIMIT);
        check("ar_ready", 32'(bus.arready), 32'd1);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bus.rvalid && n < LIMIT);
        for (int k = 0; k < rdelay; k++) begin
            check("rvalid_hold", 32'(bus.rvalid), 32'd1);
            @(negedge aclk);
        end
        check("rvalid", 32'(bus.rvalid), 32'd1);
        data       = bus.rdata;
        resp       = bus.rresp;
        bus.rready = 1'b1;
        @(posedge aclk); #1;
        bus.rready = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] resp;
        axi_write(addr, data, strb, 0, '0, resp);
        check("wr_okay", 32'(resp), 32'd0);
    endtask

    task automatic rd_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] data;
        logic [1:0]  resp;
        axi_read(addr, 0, data, resp);
        check({tag, "_resp"}, 32'(resp), 32'd0);
        check(tag, data, exp);
    endtask

    task automatic pulse(input logic [NUM_SRC-1:0] bits);
        src = src | bits;
        tick();
        src = src & ~bits;
        tick();
    endtask

    initial begin
        logic [31:0] data;
        logic [1:0]  resp;
        int          n;

        n_checks    = 0;
        n_errors    = 0;
        aresetn     = 1'b0;
        src         = '0;
        bus.awaddr  = '0;
        bus.awprot  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        repeat (3) tick();
        check("rst_awready", 32'(bus.awready), 32'd1);
        check("rst_arready", 32'(bus.arready), 32'd1);
        check("rst_wready",  32'(bus.wready),  32'd0);
        check("rst_bvalid",  32'(bus.bvalid),  32'd0);
        check("rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("rst_irq",     32'(irq),         32'd0);
        aresetn = 1'b1;
        tick();

        rd_check("rst_pending", 12'h000, 32'h0);
        rd_check("rst_enable",  12'h004, 32'h0);
        rd_check("rst_edge",    12'h008, 32'h0);
        rd_check("rst_claim",   12'h00C, 32'h0);

        // ENABLE register width and byte-strobe handling.
        wr(12'h004, 32'hFFFF_FFFF, 4'hF);
        rd_check("enable_width", 12'h004, 32'h0000_FFFF);
        wr(12'h004, 32'h0000_00A5, 4'h1);
        rd_check("enable_strb", 12'h004, 32'h0000_FFA5);

        // Level source.
        wr(12'h004, 32'h1, 4'hF);
        src[0] = 1'b1;
        tick();
        check("lvl_irq_e1", 32'(irq), 32'd0);
        tick();
        check("lvl_irq_e2", 32'(irq), 32'd1);
        rd_check("lvl_pending", 12'h000, 32'h1);
        rd_check("lvl_claim",   12'h00C, 32'h1);
        rd_check("lvl_pending_after_claim", 12'h000, 32'h1);
        src[0] = 1'b0;
        tick();
        check("lvl_fall_e1", 32'(irq), 32'd1);
        tick();
        check("lvl_fall_e2", 32'(irq), 32'd0);
        rd_check("lvl_pending_low", 12'h000, 32'h0);

        // Edge source plus claim.
        wr(12'h008, 32'h4, 4'hF);
        wr(12'h004, 32'h4, 4'hF);
        src[2] = 1'b1;
        tick();
        src[2] = 1'b0;
        check("edge_irq_e1", 32'(irq), 32'd0);
        tick();
        check("edge_irq_e2", 32'(irq), 32'd1);
        rd_check("edge_claim",   12'h00C, 32'd3);
        rd_check("edge_pending", 12'h000, 32'h0);
        check("edge_irq_drop", 32'(irq), 32'd0);
        rd_check("edge_claim2",  12'h00C, 32'd0);

        // Priority among edge sources.
        wr(12'h008, 32'hFF, 4'hF);
        wr(12'h004, 32'hFF, 4'hF);
        pulse(16'h0022);
        rd_check("prio_pending", 12'h000, 32'h22);
        rd_check("prio_claim_a", 12'h00C, 32'd2);
        rd_check("prio_claim_b", 12'h00C, 32'd6);
        rd_check("prio_claim_c", 12'h00C, 32'd0);

        // W1C with byte strobes, and set-wins collision.
        wr(12'h008, 32'hFFFF, 4'hF);
        pulse(16'h0101);
        rd_check("w1c_before", 12'h000, 32'h0101);
        wr(12'h000, 32'hFFFF, 4'h1);
        rd_check("w1c_strb", 12'h000, 32'h0100);
        pulse(16'h0001);
        rd_check("w1c_reset_up", 12'h000, 32'h0101);
        axi_write(12'h000, 32'h1, 4'h1, 0, 16'h0001, resp);
        src = '0;
        check("w1c_set_wins_resp", 32'(resp), 32'd0);
        rd_check("w1c_set_wins", 12'h000, 32'h0101);
        wr(12'h000, 32'h0101, 4'h3);
        rd_check("w1c_all", 12'h000, 32'h0);

        // Bus errors with stalled responses.
        axi_read(12'h010, 3, data, resp);
        check("decerr_rresp", 32'(resp), 32'd3);
        check("decerr_rdata", data, 32'd0);
        axi_write(12'h014, 32'h0, 4'hF, 3, '0, resp);
        check("decerr_bresp", 32'(resp), 32'd3);
        rd_check("decerr_no_change", 12'h004, 32'hFF);
        axi_write(12'h00C, 32'hFFFF_FFFF, 4'hF, 0, '0, resp);
        check("claim_wr_resp", 32'(resp), 32'd0);
        rd_check("claim_wr_noeffect", 12'h000, 32'h0);

        // Reset in the middle of a read response.
        pulse(16'h0008);
        tick();
        check("pre_rst_irq", 32'(irq), 32'd1);
        bus.araddr  = 12'h004;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bus.rvalid && n < LIMIT);
        check("mid_rvalid", 32'(bus.rvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        tick();
        check("mid_rst_irq", 32'(irq), 32'd0);
        check("mid_rst_arready", 32'(bus.arready), 32'd1);
        aresetn = 1'b1;
        tick();
        rd_check("post_rst_pending", 12'h000, 32'h0);
        rd_check("post_rst_enable",  12'h004, 32'h0);
        rd_check("post_rst_edge",    12'h008, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
